// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back port arbiter.
package wb_pkg;

    // Default register-file geometry.
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    // One queued long-latency result. live drops to 0 when a younger
    // pipeline write to the same register makes this result stale.
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] wd;
    } wb_entry_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FORCE = 2'd1,
        SLOT_PIPE  = 2'd2,
        SLOT_FIFO  = 2'd3
    } slot_e;

    // Build a fresh, live queue entry from an accepted long-latency result.
    function automatic wb_entry_t make_entry(input logic [REG_AW-1:0] rd,
                                             input logic [REG_DW-1:0] wd);
        wb_entry_t e;
        e.live = 1'b1;
        e.rd   = rd;
        e.wd   = wd;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency results with in-place WAW kill.
// Popped and never-written slots always hold live=0, so the pending mask can
// be built from every slot without tracking occupancy separately.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   kill_en,
    input  logic [REG_AW-1:0]      kill_rd,
    output wb_entry_t              head,
    output logic                   empty,
    output logic                   full,
    output logic [2**REG_AW-1:0]   pend_mask
);

    localparam int IW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [IW:0] wr_ptr;
    logic [IW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    // Storage update: kill stale entries first, then pop and push.
    // A push lands after the kill loop, so an entry enqueued at the same
    // edge as a pipeline write to its register stays live (it is younger).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].live && (mem[i].rd == kill_rd)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr[IW-1:0]].live <= 1'b0;
                rd_ptr                   <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[IW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
        end
    end

    // Occupancy flags from the wrap-bit pointer pair.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[IW] != rd_ptr[IW]) &&
                (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
        head  = mem[rd_ptr[IW-1:0]];
    end

    // Pending-write mask from live entries; x0 is never reported.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) begin
                pend_mask[mem[i].rd] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Sole owner of the register-file write port. Single-cycle pipeline results
// take priority; queued long-latency results drain in order when the pipeline
// is idle, and the queue head is forced through after a bounded wait.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_AW,
    parameter int DATA_WIDTH    = REG_DW,
    parameter int DEPTH         = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [ADDRESS_WIDTH-1:0]      pipe_rd,
    input  logic [DATA_WIDTH-1:0]         pipe_wd,
    output logic                          pipe_stall,
    input  logic                          lsu_valid,
    input  logic [ADDRESS_WIDTH-1:0]      lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_wd,
    output logic                          lsu_ready,
    output logic [2**ADDRESS_WIDTH-1:0]   pend_mask,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3
);

    // Handshakes:
    //  LSU side is valid/ready: a result transfers at a rising edge where
    //  lsu_valid && lsu_ready; lsu_ready never depends on lsu_valid.
    //  Pipeline side has no ready: a write offered with pipe_we is consumed at
    //  the edge unless pipe_stall is high, in which case upstream holds it.

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    wb_entry_t                 head;
    wb_entry_t                 push_entry;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      push;
    logic                      pop;
    logic                      kill_en;
    logic [SW-1:0]             starve_cnt;
    slot_e                     slot;
    logic                      issue_we;
    logic [ADDRESS_WIDTH-1:0]  issue_rd;
    logic [DATA_WIDTH-1:0]     issue_wd;

    // Accept side: full is the pre-pop value, so a full queue refuses a push
    // even in a cycle where it also pops. Writes to x0 are taken and dropped.
    always_comb begin
        lsu_ready  = !fifo_full && !rst;
        push       = lsu_valid && lsu_ready && (lsu_rd != '0);
        push_entry = make_entry(lsu_rd, lsu_wd);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (kill_en),
        .kill_rd    (pipe_rd),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .pend_mask  (pend_mask)
    );

    // Slot priority: starved queue head, then pipeline, then queue drain.
    always_comb begin
        slot = SLOT_IDLE;
        if ((starve_cnt == LIMIT) && head.live) begin
            slot = SLOT_FORCE;
        end else if (pipe_we && (pipe_rd != '0)) begin
            slot = SLOT_PIPE;
        end else if (!fifo_empty) begin
            slot = SLOT_FIFO;
        end
    end

    // Next write-port value for the selected slot; AD3/WD3 hold when idle.
    always_comb begin
        issue_we   = 1'b0;
        issue_rd   = AD3;
        issue_wd   = WD3;
        pop        = 1'b0;
        kill_en    = 1'b0;
        pipe_stall = 1'b0;
        case (slot)
            SLOT_FORCE: begin
                issue_we   = 1'b1;
                issue_rd   = head.rd;
                issue_wd   = head.wd;
                pop        = 1'b1;
                pipe_stall = 1'b1;
            end
            SLOT_PIPE: begin
                issue_we = 1'b1;
                issue_rd = pipe_rd;
                issue_wd = pipe_wd;
                kill_en  = 1'b1;
            end
            SLOT_FIFO: begin
                // A dead head is retired without touching the register file.
                pop      = 1'b1;
                issue_we = head.live;
                if (head.live) begin
                    issue_rd = head.rd;
                    issue_wd = head.wd;
                end
            end
            default: begin
                issue_we = 1'b0;
            end
        endcase
    end

    // Starve counter: counts cycles a live head loses to the pipeline,
    // cleared on any pop, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if ((slot == SLOT_PIPE) && head.live && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= issue_we;
            if (issue_we) begin
                AD3 <= issue_rd;
                WD3 <= issue_wd;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter against a queue-based model of the
// write-port rules and a shadow register file.
module tb_wb_port_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
        bit            live;
    } m_entry_t;

    logic              clk;
    logic              rst;
    logic              pipe_we;
    logic [AW-1:0]     pipe_rd;
    logic [DW-1:0]     pipe_wd;
    logic              pipe_stall;
    logic              lsu_valid;
    logic [AW-1:0]     lsu_rd;
    logic [DW-1:0]     lsu_wd;
    logic              lsu_ready;
    logic [2**AW-1:0]  pend_mask;
    logic              WE3;
    logic [AW-1:0]     AD3;
    logic [DW-1:0]     WD3;

    m_entry_t          mq[$];
    int                starve;
    logic [AW-1:0]     exp_ad;
    logic [DW-1:0]     exp_wd;
    logic [DW-1:0]     dut_regs[2**AW];
    logic [DW-1:0]     model_regs[2**AW];
    bit                last_stall;
    int                errors;
    int                checks;

    wb_port_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_wd    (pipe_wd),
        .pipe_stall (pipe_stall),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_wd     (lsu_wd),
        .lsu_ready  (lsu_ready),
        .pend_mask  (pend_mask),
        .WE3        (WE3),
        .AD3        (AD3),
        .WD3        (WD3)
    );

    // Clock and time-limit watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        starve = 0;
        exp_ad = '0;
        exp_wd = '0;
    endtask

    task automatic set_idle();
        pipe_we   = 1'b0;
        pipe_rd   = '0;
        pipe_wd   = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_wd    = '0;
    endtask

    // One clock cycle: inputs are already driven. Checks the combinational
    // outputs at the falling edge, advances the model by the write-port rules,
    // then checks the registered port just after the rising edge.
    task automatic step(output bit consumed, output bit accepted);
        logic [2**AW-1:0] mask;
        bit               full_m;
        bit               head_live;
        bit               force_m;
        bit               do_we;
        m_entry_t         e;
        @(negedge clk);
        full_m    = (mq.size() == DEPTH);
        head_live = (mq.size() > 0) && mq[0].live;
        force_m   = (starve == LIMIT) && head_live;
        mask = '0;
        foreach (mq[i]) if (mq[i].live) mask[mq[i].rd] = 1'b1;
        mask[0] = 1'b0;
        checks++;
        if (pipe_stall !== force_m) begin
            errors++;
            $display("FAIL pipe_stall: got %b expected %b", pipe_stall, force_m);
        end
        last_stall = (pipe_stall === 1'b1);
        checks++;
        if (lsu_ready !== !full_m) begin
            errors++;
            $display("FAIL lsu_ready: got %b expected %b", lsu_ready, !full_m);
        end
        checks++;
        if (pend_mask !== mask) begin
            errors++;
            $display("FAIL pend_mask: got %h expected %h", pend_mask, mask);
        end
        do_we = 1'b0;
        if (force_m) begin
            e = mq.pop_front();
            do_we = 1'b1; exp_ad = e.rd; exp_wd = e.wd; starve = 0;
        end else if (pipe_we && (pipe_rd != 0)) begin
            do_we = 1'b1; exp_ad = pipe_rd; exp_wd = pipe_wd;
            if (head_live && starve < LIMIT) starve++;
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            starve = 0;
            if (e.live) begin
                do_we = 1'b1; exp_ad = e.rd; exp_wd = e.wd;
            end
        end
        accepted = lsu_valid && !full_m;
        if (accepted && (lsu_rd != 0)) mq.push_back('{rd: lsu_rd, wd: lsu_wd, live: 1'b1});
        consumed = !force_m;
        if (do_we) model_regs[exp_ad] = exp_wd;
        @(posedge clk);
        #1;
        checks++;
        if (WE3 !== do_we) begin
            errors++;
            $display("FAIL WE3: got %b expected %b", WE3, do_we);
        end
        checks++;
        if (AD3 !== exp_ad || WD3 !== exp_wd) begin
            errors++;
            $display("FAIL AD3/WD3: got %0d/%h expected %0d/%h", AD3, WD3, exp_ad, exp_wd);
        end
        if (WE3 === 1'b1) begin
            checks++;
            if (AD3 === '0) begin
                errors++;
                $display("FAIL we_rd0: WE3 issued to x0 data %h", WD3);
            end
            dut_regs[AD3] = WD3;
        end
    endtask

    // Idle the inputs and let the model queue empty within a bounded time.
    task automatic drain();
        bit c;
        bit a;
        int n;
        set_idle();
        n = 0;
        while (mq.size() > 0 && n < 3 * DEPTH + LIMIT) begin
            step(c, a);
            n++;
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", mq.size());
        end
    endtask

    task automatic test_reset();
        bit c;
        bit a;
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (WE3 !== 1'b0 || AD3 !== '0 || WD3 !== '0) begin
            errors++;
            $display("FAIL reset_port: got %b/%0d/%h expected 0/0/0", WE3, AD3, WD3);
        end
        checks++;
        if (lsu_ready !== 1'b0 || pend_mask !== '0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b mask=%h stall=%b expected 0/0/0",
                     lsu_ready, pend_mask, pipe_stall);
        end
        rst = 1'b0;
        model_reset();
        // Queue three results behind a busy pipeline, then reset mid-run.
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1'b1; pipe_rd = AW'(k + 1); pipe_wd = 32'h100 + k;
            lsu_valid = 1'b1; lsu_rd = AW'(20 + k); lsu_wd = 32'h200 + k;
            step(c, a);
        end
        set_idle();
        rst = 1'b1;
        #1;
        checks++;
        if (WE3 !== 1'b0 || AD3 !== '0 || WD3 !== '0) begin
            errors++;
            $display("FAIL midrun_rst_port: got %b/%0d/%h expected 0/0/0", WE3, AD3, WD3);
        end
        checks++;
        if (lsu_ready !== 1'b0 || pend_mask !== '0) begin
            errors++;
            $display("FAIL midrun_rst_flags: ready=%b mask=%h expected 0/0", lsu_ready, pend_mask);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || pend_mask !== '0) begin
            errors++;
            $display("FAIL post_rst: ready=%b mask=%h expected 1/0", lsu_ready, pend_mask);
        end
        step(c, a);
    endtask

    task automatic test_pipe_only();
        bit c;
        bit a;
        set_idle();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
        step(c, a);
        checks++;
        if (WE3 !== 1'b1 || AD3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pipe_write: got %b/%0d/%h expected 1/5/deadbeef", WE3, AD3, WD3);
        end
        pipe_rd = 5'd0; pipe_wd = 32'h1234;
        step(c, a);
        checks++;
        if (WE3 !== 1'b0) begin
            errors++;
            $display("FAIL pipe_rd0: WE3 got %b expected 0", WE3);
        end
        drain();
    endtask

    task automatic test_lsu_drain();
        bit c;
        bit a;
        set_idle();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'hA;
        step(c, a);
        checks++;
        if (pend_mask[7] !== 1'b1) begin
            errors++;
            $display("FAIL lsu_pend7: got %b expected 1", pend_mask[7]);
        end
        lsu_rd = 5'd8; lsu_wd = 32'hB;
        step(c, a);
        checks++;
        if (WE3 !== 1'b1 || AD3 !== 5'd7 || WD3 !== 32'hA || pend_mask[7] !== 1'b0) begin
            errors++;
            $display("FAIL lsu_first: got %b/%0d/%h mask7=%b expected 1/7/a/0",
                     WE3, AD3, WD3, pend_mask[7]);
        end
        set_idle();
        step(c, a);
        checks++;
        if (WE3 !== 1'b1 || AD3 !== 5'd8 || WD3 !== 32'hB || pend_mask[8] !== 1'b0) begin
            errors++;
            $display("FAIL lsu_second: got %b/%0d/%h mask8=%b expected 1/8/b/0",
                     WE3, AD3, WD3, pend_mask[8]);
        end
        drain();
    endtask

    task automatic test_full_starve();
        bit c;
        bit a;
        int p;
        int stalls;
        p = 0;
        stalls = 0;
        for (int k = 0; k < 12; k++) begin
            pipe_we = 1'b1; pipe_rd = AW'(1 + (p % 3)); pipe_wd = 32'h1000 + p;
            lsu_valid = (k < 4); lsu_rd = AW'(10 + k); lsu_wd = 32'hA000 + k;
            step(c, a);
            if (last_stall) stalls++;
            if (c) p++;
            if (k == 3) begin
                checks++;
                if (lsu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready: got %b expected 0", lsu_ready);
                end
            end
        end
        checks++;
        if (stalls != 1) begin
            errors++;
            $display("FAIL starve_stalls: got %0d expected 1", stalls);
        end
        checks++;
        if (lsu_ready !== 1'b1 || dut_regs[10] !== 32'hA000) begin
            errors++;
            $display("FAIL starve_head: ready=%b x10=%h expected 1/a000", lsu_ready, dut_regs[10]);
        end
        drain();
    endtask

    task automatic test_waw_kill();
        bit c;
        bit a;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h111;
        step(c, a);
        pipe_rd = 5'd9; pipe_wd = 32'h55; lsu_valid = 1'b0;
        step(c, a);
        checks++;
        if (pend_mask[9] !== 1'b0) begin
            errors++;
            $display("FAIL waw_mask: got %b expected 0", pend_mask[9]);
        end
        drain();
        checks++;
        if (dut_regs[9] !== 32'h55) begin
            errors++;
            $display("FAIL waw_kill: x9 got %h expected 55", dut_regs[9]);
        end
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h2;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h222;
        step(c, a);
        pipe_rd = 5'd9; pipe_wd = 32'h66; lsu_rd = 5'd9; lsu_wd = 32'h77;
        step(c, a);
        checks++;
        if (pend_mask[9] !== 1'b1) begin
            errors++;
            $display("FAIL waw_young_mask: got %b expected 1", pend_mask[9]);
        end
        drain();
        checks++;
        if (dut_regs[9] !== 32'h77) begin
            errors++;
            $display("FAIL waw_young: x9 got %h expected 77", dut_regs[9]);
        end
    endtask

    task automatic test_random_mix();
        bit c;
        bit a;
        bit have_p;
        bit have_l;
        have_p = 1'b0;
        have_l = 1'b0;
        set_idle();
        for (int k = 0; k < 400; k++) begin
            if (!have_p) begin
                pipe_we = ($urandom_range(0, 1) == 1);
                pipe_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                      : AW'($urandom_range(0, 7));
                pipe_wd = $urandom;
            end
            if (!have_l) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = AW'($urandom_range(0, 7));
                lsu_wd    = $urandom;
            end
            step(c, a);
            have_p = pipe_we && !c;
            have_l = lsu_valid && !a;
        end
        drain();
        for (int r = 0; r < 2**AW; r++) begin
            checks++;
            if (dut_regs[r] !== model_regs[r]) begin
                errors++;
                $display("FAIL regfile_x%0d: got %h expected %h", r, dut_regs[r], model_regs[r]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_stall = 1'b0;
        for (int r = 0; r < 2**AW; r++) begin
            dut_regs[r]   = '0;
            model_regs[r] = '0;
        end
        model_reset();
        test_reset();
        test_pipe_only();
        test_lsu_drain();
        test_full_starve();
        test_waw_kill();
        test_random_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
